flow_expiry_scheduler: RTL and testbench
========================================

# flow_expiry_scheduler

Sweeps the NetFlow flow-cache table and retires aged flows. The sweep is paced by the millisecond timestamp counter's output. Each sweep walks every table entry once through a shared, arbitrated read port, then compares the entry's first-seen and last-seen timestamps against the current time. It hands each expired flow to the export path with a valid/ready handshake, then issues a clear for that entry.

## Interface
- ADDR_W, 10: table address width; the table holds 2^ADDR_W entries.
- INACTIVE_TIMEOUT, 15000: inactive timeout in ms ticks. Must be < 2^31.
- ACTIVE_TIMEOUT, 1800000: active timeout in ms ticks. Must be < 2^31.

- ACLK  in  1  clock.
- ARESETN  in  1  asynchronous, active-low reset.
- enable  in  1  allows a new sweep to start.
- timestamp_in  in  32  current time in ms, from the timestamp counter.
- tbl_gnt  in  1  read-port grant; the flow-update engine has priority.
- tbl_rd_en  out  1  read request.
- tbl_rd_addr  out  ADDR_W  read address.
- tbl_rd_vld_bit  in  1  valid bit of the entry; returned 1 cycle after the read is accepted.
- tbl_rd_first_ts  in  32  first-seen timestamp of the entry; same 1-cycle latency.
- tbl_rd_last_ts  in  32  last-seen timestamp of the entry; same 1-cycle latency.
- exp_valid  out  1  export request.
- exp_ready  in  1  export accept.
- exp_addr  out  ADDR_W  address of the expired entry.
- exp_reason  out  2  expiry reason: bit0 = inactive, bit1 = active.
- tbl_clr_en  out  1  one-cycle clear strobe.
- tbl_clr_addr  out  ADDR_W  address to clear.
- sweep_done  out  1  one-cycle pulse when a sweep completes.
- exp_count  out  32  total exports accepted; wraps modulo 2^32.

## Operation
- State machine states: IDLE, READ, WAIT, EVAL, EXPORT, CLEAR.
- IDLE → READ when enable=1 and timestamp_in != sweep_ts.
  - On this transition: sweep_ts <= timestamp_in and scan_addr <= 0.
  - Effect: at most one sweep starts per ms tick.
- READ: assert tbl_rd_en with tbl_rd_addr = scan_addr.
  - The read is accepted in any cycle where tbl_rd_en=1 and tbl_gnt=1; the FSM then goes to WAIT.
  - Otherwise the FSM stays in READ with the address held stable.
- WAIT: capture the valid bit, first-seen and last-seen timestamps into registers; go to EVAL.
- EVAL computes, with all arithmetic modulo 2^32 (wrap-safe):
  - idle_age = timestamp_in − last_ts.
  - life_age = timestamp_in − first_ts.
  - reason[0] = (idle_age >= INACTIVE_TIMEOUT); reason[1] = (life_age >= ACTIVE_TIMEOUT).
- EVAL transitions:
  - Entry valid and reason != 0: go to EXPORT.
  - Otherwise: advance.
- EXPORT:
  - exp_valid=1; exp_addr and exp_reason are held constant until exp_ready=1.
  - On handshake: increment exp_count and go to CLEAR.
- CLEAR: tbl_clr_en=1 for exactly 1 cycle with tbl_clr_addr = exp_addr; then advance.
- Advance:
  - If scan_addr is the last entry (all ones): pulse sweep_done and go to IDLE.
  - If enable=0: go to IDLE without pulsing sweep_done. The next sweep restarts at address 0.
  - Otherwise: scan_addr + 1 and go to READ.
- enable dropping mid-sweep does not abort the current entry, including a pending EXPORT/CLEAR.
- timestamp_in changing mid-sweep: EVAL always uses the live timestamp_in value.

## Timing
- Reset values: every output is 0. Internally, state=IDLE, scan_addr=0, sweep_ts=0.
  - Consequence: the first sweep starts once timestamp_in becomes nonzero.
- Reset asserted mid-operation clears exp_valid and tbl_clr_en immediately, because reset is asynchronous. Any in-flight entry is dropped.
- Per-entry cost:
  - Not expired, no grant stall: 3 cycles (READ, WAIT, EVAL).
  - Expired: 3 + handshake wait + 1 cycle for CLEAR.
- Full sweep, no stalls and no exports: 3·2^ADDR_W cycles, plus 1 cycle from IDLE to READ.
- sweep_done is asserted in the EVAL or CLEAR cycle of the last entry.
- tbl_clr_en rises in the cycle after the exp_valid && exp_ready handshake.
- exp_valid never drops without a handshake, except on reset.

## Structure
- Shared package flow_sched_pkg holds:
  - the state enum;
  - the reason bit positions (REASON_INACTIVE=0, REASON_ACTIVE=1);
  - the timestamp width constant TS_W=32.
- Sub-module flow_age_cmp: combinational. Takes timestamp_in, first_ts, last_ts and the two timeouts; outputs the 2-bit reason.
- The top level instantiates flow_age_cmp and the FSM.

## Test plan
- Test parameterization: all directed scenarios use ADDR_W=2 with the default timeouts (INACTIVE_TIMEOUT=15000, ACTIVE_TIMEOUT=1800000); the 3·4 cycle sweep figure below follows from ADDR_W=2.
- All entries invalid, tbl_gnt=1, timestamp_in 0→1:
  - sweep_done pulses exactly 13 cycles after the change (1 + 3·4).
  - exp_valid stays 0.
  - No second sweep starts until timestamp_in=2.
- Entry 2 valid, last_ts=100, first_ts=100, timestamp_in=15100:
  - exp_valid with exp_addr=2, exp_reason=01.
  - tbl_clr_addr=2 pulsed in the cycle after the handshake.
  - exp_count=1.
- Wrap case: last_ts=0xFFFF_FFF0, timestamp_in=0x0000_3A90 (age 15008):
  - export with reason=01.
  - With timestamp_in=0x0000_3A80 (age 14992): no export.
- Backpressure: exp_ready low for 5 cycles:
  - exp_valid, exp_addr and exp_reason are stable throughout.
  - tbl_clr_en is a single pulse after acceptance.
- tbl_gnt low for 4 cycles during READ:
  - tbl_rd_en stays 1 with tbl_rd_addr unchanged.
  - Scan resumes on the cycle after the grant.
- ARESETN pulsed low during EXPORT:
  - all outputs are 0 while reset is low.
  - After release, the next sweep starts at address 0 with exp_count=0.

Source files
------------

// File: rtl/flow_expiry_scheduler_pkg.sv
// Shared types and constants for the flow expiry scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package flow_sched_pkg;

  localparam int TS_W            = 32;
  localparam int REASON_INACTIVE = 0;
  localparam int REASON_ACTIVE   = 1;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    EVAL,
    EXPORT,
    CLEAR
  } state_t;

endpackage

// File: rtl/flow_expiry_scheduler_if.sv
// Table read port, export handshake and clear strobe of the expiry scheduler.
// Latency: n/a (wires only); read data returns 1 cycle after an accepted read.
// Backpressure: tbl_gnt stalls reads, exp_ready stalls exports.
// master = scheduler side, slave = flow table / export path side.
interface flow_expiry_scheduler_if #(
  parameter int ADDR_W = 10
);
  import flow_sched_pkg::*;

  logic              tbl_gnt;
  logic              tbl_rd_en;
  logic [ADDR_W-1:0] tbl_rd_addr;
  logic              tbl_rd_vld_bit;
  logic [TS_W-1:0]   tbl_rd_first_ts;
  logic [TS_W-1:0]   tbl_rd_last_ts;
  logic              exp_valid;
  logic              exp_ready;
  logic [ADDR_W-1:0] exp_addr;
  logic [1:0]        exp_reason;
  logic              tbl_clr_en;
  logic [ADDR_W-1:0] tbl_clr_addr;

  modport master (
    input  tbl_gnt, tbl_rd_vld_bit, tbl_rd_first_ts, tbl_rd_last_ts, exp_ready,
    output tbl_rd_en, tbl_rd_addr, exp_valid, exp_addr, exp_reason,
           tbl_clr_en, tbl_clr_addr
  );

  modport slave (
    output tbl_gnt, tbl_rd_vld_bit, tbl_rd_first_ts, tbl_rd_last_ts, exp_ready,
    input  tbl_rd_en, tbl_rd_addr, exp_valid, exp_addr, exp_reason,
           tbl_clr_en, tbl_clr_addr
  );

endinterface

// File: rtl/flow_expiry_scheduler_age_cmp.sv
// Flow age comparator: flags inactive / active timeout for one table entry.
// Latency: combinational.
// Backpressure: none.
// Ports: timestamp_in/first_ts/last_ts and the two timeouts in, 2-bit reason out.
module flow_age_cmp
  import flow_sched_pkg::*;
(
  input  logic [TS_W-1:0] timestamp_in,
  input  logic [TS_W-1:0] first_ts,
  input  logic [TS_W-1:0] last_ts,
  input  logic [TS_W-1:0] inactive_timeout,
  input  logic [TS_W-1:0] active_timeout,
  output logic [1:0]      reason
);

  logic [TS_W-1:0] idle_age;
  logic [TS_W-1:0] life_age;

  // Modulo-2^32 subtraction keeps ages correct across timestamp wrap,
  // as long as the real age stays below 2^31.
  always_comb begin
    idle_age                = timestamp_in - last_ts;
    life_age                = timestamp_in - first_ts;
    reason                  = '0;
    reason[REASON_INACTIVE] = (idle_age >= inactive_timeout);
    reason[REASON_ACTIVE]   = (life_age >= active_timeout);
  end

endmodule

// File: rtl/flow_expiry_scheduler.sv
// Flow-cache sweeper: walks every entry once per ms tick, exports and clears aged flows.
// Latency: 3 cycles per live entry; expired entries add the export wait plus 1 clear cycle.
// Backpressure: holds the read request while tbl_gnt=0, holds export while exp_ready=0.
// Ports: ACLK/ARESETN, enable, timestamp_in, tbl (table/export bus), sweep_done, exp_count.
module flow_expiry_scheduler
  import flow_sched_pkg::*;
#(
  parameter int ADDR_W           = 10,
  parameter int INACTIVE_TIMEOUT = 15000,
  parameter int ACTIVE_TIMEOUT   = 1800000
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  input  logic                   enable,
  input  logic [TS_W-1:0]        timestamp_in,
  flow_expiry_scheduler_if.master tbl,
  output logic                   sweep_done,
  output logic [31:0]            exp_count
);

  localparam logic [TS_W-1:0]   INACT_T   = TS_W'(INACTIVE_TIMEOUT);
  localparam logic [TS_W-1:0]   ACT_T     = TS_W'(ACTIVE_TIMEOUT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] scan_addr_q, scan_addr_d;
  logic [TS_W-1:0]   sweep_ts_q, sweep_ts_d;
  logic              vld_q, vld_d;
  logic [TS_W-1:0]   first_ts_q, first_ts_d;
  logic [TS_W-1:0]   last_ts_q, last_ts_d;
  logic [ADDR_W-1:0] exp_addr_q, exp_addr_d;
  logic [1:0]        exp_reason_q, exp_reason_d;
  logic [31:0]       exp_count_q, exp_count_d;
  logic [1:0]        reason;
  logic              advance;

  flow_age_cmp u_age_cmp (
    .timestamp_in     (timestamp_in),
    .first_ts         (first_ts_q),
    .last_ts          (last_ts_q),
    .inactive_timeout (INACT_T),
    .active_timeout   (ACT_T),
    .reason           (reason)
  );

  always_comb begin
    state_d        = state_q;
    scan_addr_d    = scan_addr_q;
    sweep_ts_d     = sweep_ts_q;
    vld_d          = vld_q;
    first_ts_d     = first_ts_q;
    last_ts_d      = last_ts_q;
    exp_addr_d     = exp_addr_q;
    exp_reason_d   = exp_reason_q;
    exp_count_d    = exp_count_q;
    tbl.tbl_rd_en  = 1'b0;
    tbl.exp_valid  = 1'b0;
    tbl.tbl_clr_en = 1'b0;
    sweep_done     = 1'b0;
    advance        = 1'b0;

    case (state_q)
      IDLE: begin
        // Remembering the start tick limits us to one sweep per ms.
        if (enable && (timestamp_in != sweep_ts_q)) begin
          sweep_ts_d  = timestamp_in;
          scan_addr_d = '0;
          state_d     = READ;
        end
      end
      READ: begin
        tbl.tbl_rd_en = 1'b1;
        if (tbl.tbl_gnt) state_d = WAIT;
      end
      WAIT: begin
        vld_d      = tbl.tbl_rd_vld_bit;
        first_ts_d = tbl.tbl_rd_first_ts;
        last_ts_d  = tbl.tbl_rd_last_ts;
        state_d    = EVAL;
      end
      EVAL: begin
        if (vld_q && (reason != 2'b00)) begin
          exp_addr_d   = scan_addr_q;
          exp_reason_d = reason;
          state_d      = EXPORT;
        end else begin
          advance = 1'b1;
        end
      end
      EXPORT: begin
        tbl.exp_valid = 1'b1;
        if (tbl.exp_ready) begin
          exp_count_d = exp_count_q + 32'd1;
          state_d     = CLEAR;
        end
      end
      CLEAR: begin
        tbl.tbl_clr_en = 1'b1;
        advance        = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Finishing the last entry wins over enable; a dropped enable ends the
    // sweep silently and the next one restarts from entry 0.
    if (advance) begin
      if (scan_addr_q == LAST_ADDR) begin
        sweep_done = 1'b1;
        state_d    = IDLE;
      end else if (!enable) begin
        state_d = IDLE;
      end else begin
        scan_addr_d = scan_addr_q + 1'b1;
        state_d     = READ;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q      <= IDLE;
      scan_addr_q  <= '0;
      sweep_ts_q   <= '0;
      vld_q        <= 1'b0;
      first_ts_q   <= '0;
      last_ts_q    <= '0;
      exp_addr_q   <= '0;
      exp_reason_q <= '0;
      exp_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      scan_addr_q  <= scan_addr_d;
      sweep_ts_q   <= sweep_ts_d;
      vld_q        <= vld_d;
      first_ts_q   <= first_ts_d;
      last_ts_q    <= last_ts_d;
      exp_addr_q   <= exp_addr_d;
      exp_reason_q <= exp_reason_d;
      exp_count_q  <= exp_count_d;
    end
  end

  assign tbl.tbl_rd_addr  = scan_addr_q;
  assign tbl.exp_addr     = exp_addr_q;
  assign tbl.exp_reason   = exp_reason_q;
  assign tbl.tbl_clr_addr = exp_addr_q;
  assign exp_count        = exp_count_q;

endmodule

// File: tb/tb_flow_expiry_scheduler.sv
// Bench for flow_expiry_scheduler (ADDR_W=2, default timeouts).
// Latency: n/a.
// Backpressure: drives tbl_gnt / exp_ready directly or randomly.
module tb_flow_expiry_scheduler;
  import flow_sched_pkg::*;

  localparam int          AW      = 2;
  localparam int          N       = 4;
  localparam logic [31:0] T_INACT = 32'd15000;
  localparam logic [31:0] T_ACT   = 32'd1800000;

  logic          ACLK = 1'b0;
  logic          ARESETN;
  logic          enable = 1'b0;
  logic [31:0]   timestamp_in = '0;
  logic          sweep_done;
  logic [31:0]   exp_count;

  flow_expiry_scheduler_if #(.ADDR_W(AW)) bus ();

  flow_expiry_scheduler #(
    .ADDR_W(AW), .INACTIVE_TIMEOUT(15000), .ACTIVE_TIMEOUT(1800000)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .enable(enable), .timestamp_in(timestamp_in),
    .tbl(bus), .sweep_done(sweep_done), .exp_count(exp_count)
  );

  always #5 ACLK = ~ACLK;

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", nm, got, want, $time);
    end
  endfunction

  // Flow table: static contents, read data returned 1 cycle after an accepted read.
  logic        t_vld   [N];
  logic [31:0] t_first [N];
  logic [31:0] t_last  [N];
  logic        rd_vld_r   = 1'b0;
  logic [31:0] rd_first_r = '0;
  logic [31:0] rd_last_r  = '0;

  always @(posedge ACLK) begin
    if (bus.tbl_rd_en && bus.tbl_gnt) begin
      rd_vld_r   <= t_vld[bus.tbl_rd_addr];
      rd_first_r <= t_first[bus.tbl_rd_addr];
      rd_last_r  <= t_last[bus.tbl_rd_addr];
    end
  end
  assign bus.tbl_rd_vld_bit  = rd_vld_r;
  assign bus.tbl_rd_first_ts = rd_first_r;
  assign bus.tbl_rd_last_ts  = rd_last_r;

  // Grant / ready: forced low, random, or always high.
  logic rnd_on = 1'b0, gnt_low = 1'b0, rdy_low = 1'b0;
  logic gnt_rnd = 1'b1, rdy_rnd = 1'b1;
  always @(negedge ACLK) begin
    gnt_rnd = ($urandom_range(3) != 0);
    rdy_rnd = ($urandom_range(2) != 0);
  end
  assign bus.tbl_gnt   = !gnt_low && (!rnd_on || gnt_rnd);
  assign bus.exp_ready = !rdy_low && (!rnd_on || rdy_rnd);

  // Reference model: which entries of a sweep must be exported, in order.
  function automatic logic [1:0] model_reason(input logic [31:0] ts, input logic [31:0] first,
                                              input logic [31:0] last);
    logic [31:0] idle_age, life_age;
    idle_age = ts - last;
    life_age = ts - first;
    return {life_age >= T_ACT, idle_age >= T_INACT};
  endfunction

  logic [AW-1:0] exp_a [1024];
  logic [1:0]    exp_r [1024];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  int            model_count = 0;

  task automatic push_expected(input logic [31:0] ts);
    for (int a = 0; a < N; a++) begin
      logic [1:0] r;
      r = model_reason(ts, t_first[a], t_last[a]);
      if (t_vld[a] && (r != 2'b00)) begin
        exp_a[wr_ptr % 1024] = a[AW-1:0];
        exp_r[wr_ptr % 1024] = r;
        wr_ptr++;
      end
    end
  endtask

  task automatic start_sweep(input logic [31:0] ts);
    push_expected(ts);
    timestamp_in = ts;
  endtask

  // Per-cycle compare against the model and the handshake rules.
  logic          p_hs = 1'b0, p_vstall = 1'b0, p_rstall = 1'b0, p_racc = 1'b0;
  logic [AW-1:0] p_eaddr = '0, p_raddr = '0;
  logic [1:0]    p_rsn = '0;

  always @(negedge ACLK) begin
    logic hs;
    #1;
    if (!ARESETN) begin
      rd_ptr      = wr_ptr;
      model_count = 0;
      p_hs = 1'b0; p_vstall = 1'b0; p_rstall = 1'b0; p_racc = 1'b0;
    end else begin
      chk("exp_count", exp_count, model_count);
      chk("clr_en", {31'd0, bus.tbl_clr_en}, {31'd0, p_hs});
      if (p_hs) chk("clr_addr", bus.tbl_clr_addr, p_eaddr);
      if (p_vstall) begin
        chk("hold_exp_valid", bus.exp_valid, 1);
        chk("hold_exp_addr", bus.exp_addr, p_eaddr);
        chk("hold_exp_reason", bus.exp_reason, p_rsn);
      end
      if (p_rstall) begin
        chk("hold_rd_en", bus.tbl_rd_en, 1);
        chk("hold_rd_addr", bus.tbl_rd_addr, p_raddr);
      end
      if (p_racc) chk("rd_en_after_accept", bus.tbl_rd_en, 0);
      if (sweep_done) chk("exports_left_at_done", wr_ptr - rd_ptr, 0);
      hs = bus.exp_valid && bus.exp_ready;
      if (hs) begin
        chk("export_expected", {31'd0, wr_ptr != rd_ptr}, 1);
        if (wr_ptr != rd_ptr) begin
          chk("exp_addr", bus.exp_addr, exp_a[rd_ptr % 1024]);
          chk("exp_reason", bus.exp_reason, exp_r[rd_ptr % 1024]);
          rd_ptr++;
        end
        model_count++;
      end
      p_hs     = hs;
      p_eaddr  = bus.exp_addr;
      p_rsn    = bus.exp_reason;
      p_vstall = bus.exp_valid && !bus.exp_ready;
      p_rstall = bus.tbl_rd_en && !bus.tbl_gnt;
      p_racc   = bus.tbl_rd_en && bus.tbl_gnt;
      p_raddr  = bus.tbl_rd_addr;
    end
  end

  task automatic wait_done();
    int n;
    n = 0;
    while (!sweep_done && n < 3000) begin
      @(negedge ACLK);
      n++;
    end
    if (!sweep_done) chk("sweep_done_timeout", 0, 1);
    @(negedge ACLK);
  endtask

  task automatic wait_exp_valid();
    int n;
    n = 0;
    while (!bus.exp_valid && n < 200) begin
      @(negedge ACLK);
      n++;
    end
    if (!bus.exp_valid) chk("exp_valid_timeout", 0, 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_rd_en"}, bus.tbl_rd_en, 0);
    chk({tag, "_rd_addr"}, bus.tbl_rd_addr, 0);
    chk({tag, "_exp_valid"}, bus.exp_valid, 0);
    chk({tag, "_exp_addr"}, bus.exp_addr, 0);
    chk({tag, "_exp_reason"}, bus.exp_reason, 0);
    chk({tag, "_clr_en"}, bus.tbl_clr_en, 0);
    chk({tag, "_clr_addr"}, bus.tbl_clr_addr, 0);
    chk({tag, "_sweep_done"}, sweep_done, 0);
    chk({tag, "_exp_count"}, exp_count, 0);
  endtask

  initial begin
    int n, vcnt, ccnt, bad_cyc;
    logic [31:0] ts;
    for (int a = 0; a < N; a++) begin
      t_vld[a] = 1'b0; t_first[a] = '0; t_last[a] = '0;
    end

    // Pin the model on hand-computed cases.
    chk("model_basic", model_reason(32'd15100, 32'd100, 32'd100), 32'd1);
    chk("model_wrap_hit", model_reason(32'h3A90, 32'hFFFF_FFF0, 32'hFFFF_FFF0), 32'd1);
    chk("model_wrap_miss", model_reason(32'h3A80, 32'hFFFF_FFF0, 32'hFFFF_FFF0), 32'd0);
    chk("model_below", model_reason(32'd14999, 32'd0, 32'd0), 32'd0);
    chk("model_both", model_reason(32'd1800000, 32'd0, 32'd0), 32'd3);

    // Reset state, then no sweep while timestamp_in is still 0.
    ARESETN = 1'b1;
    #1 ARESETN = 1'b0;
    #2 check_outputs_zero("reset");
    @(negedge ACLK);
    #2 ARESETN = 1'b1;
    enable = 1'b1;
    n = 0;
    repeat (5) begin @(negedge ACLK); n += bus.tbl_rd_en; end
    chk("no_sweep_at_ts0", n, 0);

    // All entries invalid, timestamp 0 -> 1.
    start_sweep(32'd1);
    n = 1; vcnt = 0;
    while (!sweep_done && n < 100) begin
      @(negedge ACLK);
      n++;
      vcnt += bus.exp_valid;
    end
    chk("sweep_len_cycles", n, 13);
    chk("invalid_no_export", vcnt, 0);
    n = 0;
    repeat (10) begin @(negedge ACLK); n += bus.tbl_rd_en; end
    chk("one_sweep_per_tick", n, 0);
    start_sweep(32'd2);
    @(negedge ACLK);
    chk("restart_rd_en", bus.tbl_rd_en, 1);
    chk("restart_rd_addr", bus.tbl_rd_addr, 0);
    wait_done();

    // Entry 2 inactive-expired.
    t_vld[2] = 1'b1; t_first[2] = 32'd100; t_last[2] = 32'd100;
    start_sweep(32'd15100);
    wait_exp_valid();
    chk("lit_exp_addr", bus.exp_addr, 2);
    chk("lit_exp_reason", bus.exp_reason, 1);
    @(negedge ACLK);
    chk("lit_clr_en", bus.tbl_clr_en, 1);
    chk("lit_clr_addr", bus.tbl_clr_addr, 2);
    chk("lit_exp_count", exp_count, 1);
    wait_done();

    // Timestamp wrap.
    t_first[2] = 32'hFFFF_FFF0; t_last[2] = 32'hFFFF_FFF0;
    start_sweep(32'h0000_3A90);
    wait_exp_valid();
    chk("wrap_reason", bus.exp_reason, 1);
    wait_done();
    start_sweep(32'h0000_3A80);
    vcnt = 0; n = 0;
    while (!sweep_done && n < 100) begin
      @(negedge ACLK);
      n++;
      vcnt += bus.exp_valid;
    end
    chk("wrap_short_no_export", vcnt, 0);
    @(negedge ACLK);

    // Export backpressure for 5 cycles.
    rdy_low = 1'b1;
    start_sweep(32'h0000_3A90 + 32'd100);
    wait_exp_valid();
    vcnt = 1;
    repeat (4) begin @(negedge ACLK); vcnt += bus.exp_valid; end
    rdy_low = 1'b0;
    ccnt = 0; n = 0;
    while (!sweep_done && n < 100) begin
      @(negedge ACLK);
      n++;
      vcnt += bus.exp_valid;
      ccnt += bus.tbl_clr_en;
    end
    chk("bp_valid_cycles", vcnt, 5);
    chk("bp_clr_pulses", ccnt, 1);
    @(negedge ACLK);

    // Grant withheld for 4 cycles on the first read.
    gnt_low = 1'b1;
    start_sweep(32'h0000_3A90 + 32'd200);
    bad_cyc = 0;
    repeat (4) begin
      @(negedge ACLK);
      if (!(bus.tbl_rd_en && bus.tbl_rd_addr == '0)) bad_cyc++;
    end
    chk("gnt_stall_held", bad_cyc, 0);
    gnt_low = 1'b0;
    @(negedge ACLK);
    chk("gnt_resume", bus.tbl_rd_en, 0);
    wait_done();

    // Reset pulsed during EXPORT.
    rdy_low = 1'b1;
    ts = 32'h0000_3A90 + 32'd300;
    start_sweep(ts);
    wait_exp_valid();
    #2 ARESETN = 1'b0;
    #1 check_outputs_zero("midreset");
    @(negedge ACLK);
    @(negedge ACLK);
    #2;
    push_expected(ts);
    rdy_low = 1'b0;
    ARESETN = 1'b1;
    @(negedge ACLK);
    chk("post_reset_rd_en", bus.tbl_rd_en, 1);
    chk("post_reset_rd_addr", bus.tbl_rd_addr, 0);
    chk("post_reset_exp_count", exp_count, 0);
    wait_done();

    // Randomized sweeps with random grant / ready.
    rnd_on = 1'b1;
    for (int s = 0; s < 60; s++) begin
      ts = ts + 32'd1 + $urandom_range(100000);
      for (int a = 0; a < N; a++) begin
        logic [31:0] ia, la;
        case ($urandom_range(5))
          0: ia = $urandom_range(14990);
          1: ia = 32'd14999;
          2: ia = 32'd15000;
          3: ia = 32'd15001;
          4: ia = $urandom;
          default: ia = $urandom_range(20000);
        endcase
        case ($urandom_range(4))
          0: la = 32'd1799999;
          1: la = 32'd1800000;
          2: la = $urandom_range(1799998);
          3: la = $urandom;
          default: la = 32'd1800001;
        endcase
        t_vld[a]   = ($urandom_range(9) < 7);
        t_last[a]  = ts - ia;
        t_first[a] = ts - la;
      end
      start_sweep(ts);
      wait_done();
    end
    rnd_on = 1'b0;
    repeat (3) @(negedge ACLK);
    chk("all_exports_seen", wr_ptr - rd_ptr, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
